input_deserializer: RTL

- Collects a stream of dataWidth-bit words, one per handshake, and packs them into the wide numInputs*dataWidth vector consumed as layerIn by layer 0.
- Performs the inverse of the layer-input serializer. It sits between the pixel source (UART/stream front end) and the first network layer.
- Provides a valid/ready handshake on both sides, frame-boundary checking via inLast, and a synchronous clear.

---
 rtl/input_deserializer_pkg.sv | 12 +
 rtl/input_deserializer.sv | 96 +++++++++
 2 files changed

// File: rtl/input_deserializer_pkg.sv
// Types and default sizes shared by the input deserializer and the layer modules.
package input_deserializer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } deser_state_t;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_INPUTS = 784;

endpackage

// File: rtl/input_deserializer.sv
// Packs a handshaked stream of dataWidth-bit words into one numInputs*dataWidth frame for layer 0,
// with inLast frame-boundary checking and a synchronous clear.
module input_deserializer
    import input_deserializer_pkg::*;
#(
    parameter int numInputs    = NUM_INPUTS,
    parameter int dataWidth    = DATA_WIDTH,
    parameter int counterWidth = $clog2(numInputs + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic [dataWidth-1:0]            inData,
    input  logic                            inValid,
    input  logic                            inLast,
    output logic                            inReady,
    output logic [dataWidth*numInputs-1:0]  layerOut,
    output logic                            layerOutValid,
    input  logic                            outReady,
    output logic                            frameError
);

    localparam logic [counterWidth-1:0] LAST_INDEX = counterWidth'(numInputs - 1);

    deser_state_t                     state_q, state_d;
    logic [counterWidth-1:0]          count_q, count_d;
    logic [dataWidth*numInputs-1:0]   layer_q, layer_d;
    logic                             frame_error_q, frame_error_d;
    logic                             accept;

    assign inReady       = (state_q == FILL);
    assign layerOutValid = (state_q == FULL);
    assign layerOut      = layer_q;
    assign frameError    = frame_error_q;

    // A word offered alongside clear is dropped even though inReady may be high.
    assign accept = inValid && inReady && !clear;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        layer_d       = layer_q;
        frame_error_d = 1'b0;

        if (clear) begin
            state_d = FILL;
            count_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        layer_d[int'(count_q)*dataWidth +: dataWidth] = inData;
                        if (count_q == LAST_INDEX) begin
                            count_d = '0;
                            if (inLast) begin
                                state_d = FULL;
                            end else begin
                                frame_error_d = 1'b1;
                            end
                        end else if (inLast) begin
                            // Stale slices from the aborted frame are simply overwritten later.
                            count_d       = '0;
                            frame_error_d = 1'b1;
                        end else begin
                            count_d = count_q + counterWidth'(1);
                        end
                    end
                end
                FULL: begin
                    if (outReady) begin
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FILL;
            count_q       <= '0;
            layer_q       <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            layer_q       <= layer_d;
            frame_error_q <= frame_error_d;
        end
    end

endmodule
